// File: rtl/cruise_speed_if.sv
// Cruise-control bundle between the driver inputs, the speed counter and the control FSM.
// The FSM sits on the master side; the driver and counter sit on the slave side.
interface cruise_speed_if;
    logic       power;
    logic       set;
    logic       resume;
    logic       cancel;
    logic       brake;
    logic       accel;
    logic       decel;
    logic [2:0] speed_cnt;
    logic       cnt_enable;
    logic       cnt_mode;
    logic       cnt_clear;
    logic [2:0] target;
    logic [1:0] state;
    logic       engaged;

    modport master (
        input  power, set, resume, cancel, brake, accel, decel, speed_cnt,
        output cnt_enable, cnt_mode, cnt_clear, target, state, engaged
    );

    modport slave (
        output power, set, resume, cancel, brake, accel, decel, speed_cnt,
        input  cnt_enable, cnt_mode, cnt_clear, target, state, engaged
    );
endinterface

// File: rtl/cruise_speed_fsm.sv
// Cruise-control stage: turns driver inputs into up/down counter controls and
// steps the 3-bit speed counter toward a held target at one step per TICK_DIV cycles.
module cruise_speed_fsm #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic           clk,
    input  logic           clear_n,
    cruise_speed_if.master bus
);
    typedef enum logic [1:0] {
        S_OFF    = 2'b00,
        S_IDLE   = 2'b01,
        S_CRUISE = 2'b10,
        S_STBY   = 2'b11
    } state_t;

    state_t     st, st_nxt;
    logic [7:0] tick_cnt;
    logic       tick;
    logic [2:0] tgt, tgt_nxt;
    logic       want, dn, step;
    logic       en_d, mode_d, clr_d, eng_d;
    logic       en_q, mode_q, clr_q, eng_q;

    assign tick = (st != S_OFF) && (tick_cnt == 8'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) st <= S_OFF;
        else          st <= st_nxt;
    end

    // Brake and cancel outrank set/resume, so they also block engagement.
    always_comb begin
        st_nxt  = st;
        tgt_nxt = tgt;
        if (!bus.power) begin
            st_nxt  = S_OFF;
            tgt_nxt = '0;
        end else begin
            case (st)
                S_OFF: st_nxt = S_IDLE;
                S_IDLE, S_STBY: begin
                    if (!bus.brake && !bus.cancel) begin
                        if (bus.set) begin
                            st_nxt  = S_CRUISE;
                            tgt_nxt = bus.speed_cnt;
                        end else if (bus.resume && st == S_STBY) begin
                            st_nxt = S_CRUISE;
                        end
                    end
                end
                S_CRUISE: begin
                    if (bus.brake || bus.cancel) begin
                        st_nxt = S_STBY;
                    end else if (bus.set) begin
                        tgt_nxt = bus.speed_cnt;
                    end else if (tick && (bus.accel ^ bus.decel)) begin
                        if (bus.accel) tgt_nxt = (tgt == 3'd7) ? tgt : tgt + 3'd1;
                        else           tgt_nxt = (tgt == 3'd0) ? tgt : tgt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A disengaging cruise cycle takes no step; the counter never wraps.
    always_comb begin
        want = 1'b0;
        dn   = 1'b0;
        case (st)
            S_IDLE, S_STBY: begin
                if (bus.brake) begin
                    want = 1'b1;
                    dn   = 1'b1;
                end else if (bus.accel ^ bus.decel) begin
                    want = 1'b1;
                    dn   = bus.decel;
                end
            end
            S_CRUISE: begin
                if (!bus.brake && !bus.cancel && bus.speed_cnt != tgt) begin
                    want = 1'b1;
                    dn   = bus.speed_cnt > tgt;
                end
            end
            default: ;
        endcase
        step   = tick && bus.power && want &&
                 (dn ? (bus.speed_cnt != 3'd0) : (bus.speed_cnt != 3'd7));
        en_d   = step;
        mode_d = step && dn;
        clr_d  = (st_nxt == S_OFF);
        eng_d  = (st_nxt == S_CRUISE);
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            tick_cnt <= '0;
            tgt      <= '0;
            en_q     <= 1'b0;
            mode_q   <= 1'b0;
            clr_q    <= 1'b1;
            eng_q    <= 1'b0;
        end else begin
            tick_cnt <= (st == S_OFF || tick) ? 8'd0 : tick_cnt + 8'd1;
            tgt      <= tgt_nxt;
            en_q     <= en_d;
            mode_q   <= mode_d;
            clr_q    <= clr_d;
            eng_q    <= eng_d;
        end
    end

    assign bus.cnt_enable = en_q;
    assign bus.cnt_mode   = mode_q;
    assign bus.cnt_clear  = clr_q;
    assign bus.target     = tgt;
    assign bus.state      = st;
    assign bus.engaged    = eng_q;
endmodule

// File: tb/tb_cruise_speed_fsm.sv
// Bench for cruise_speed_fsm: behavioural counter on the cnt_* outputs plus a
// cycle-level reference model of the cruise rules, checked every cycle.
module tb_cruise_speed_fsm;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic clear_n = 1'b0;
    always #5 clk = ~clk;

    cruise_speed_if bus ();
    cruise_speed_fsm #(.TICK_DIV(TD)) dut (.clk(clk), .clear_n(clear_n), .bus(bus));

    // Speed counter driven by the DUT controls
    logic [2:0] cnt = 3'd0;
    always @(posedge clk) begin
        if (bus.cnt_clear)       cnt <= 3'd0;
        else if (bus.cnt_enable) cnt <= bus.cnt_mode ? cnt - 3'd1 : cnt + 3'd1;
    end
    assign bus.speed_cnt = cnt;

    int tests = 0;
    int fails = 0;

    // Reference model: 0=OFF 1=IDLE 2=CRUISE 3=STANDBY
    int m_state, m_tgt, m_phase, m_spd;
    bit m_en, m_mode, m_clr, prev_en;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_tgt = 0; m_phase = 0;
        m_en = 0; m_mode = 0; m_clr = 1;
    endtask

    task automatic model_clk();
        int  spd_n, n_state, n_tgt;
        bit  tick, want, dn;
        spd_n = m_clr ? 0 : (m_en ? (m_mode ? m_spd - 1 : m_spd + 1) : m_spd);
        if (!clear_n) begin
            model_reset();
            m_spd = spd_n;
            return;
        end
        tick = (m_state != 0) && (m_phase == TD - 1);
        n_state = m_state;
        n_tgt = m_tgt;
        want = 0;
        dn = 0;
        if (!bus.power) begin
            n_state = 0;
            n_tgt = 0;
        end else if (m_state == 0) begin
            n_state = 1;
        end else if (m_state == 2) begin
            if (bus.brake || bus.cancel) n_state = 3;
            else if (bus.set) n_tgt = m_spd;
            else if (tick && bus.accel != bus.decel)
                n_tgt = bus.accel ? ((m_tgt < 7) ? m_tgt + 1 : 7) : ((m_tgt > 0) ? m_tgt - 1 : 0);
            if (tick && !bus.brake && !bus.cancel && m_spd != m_tgt) begin
                want = 1;
                dn = m_spd > m_tgt;
            end
        end else begin
            if (!bus.brake && !bus.cancel) begin
                if (bus.set) begin
                    n_state = 2;
                    n_tgt = m_spd;
                end else if (bus.resume && m_state == 3) begin
                    n_state = 2;
                end
            end
            if (tick && bus.brake) begin
                want = 1;
                dn = 1;
            end else if (tick && bus.accel != bus.decel) begin
                want = 1;
                dn = bus.decel;
            end
        end
        if (!bus.power) want = 0;
        if (want && dn && m_spd == 0) want = 0;
        if (want && !dn && m_spd == 7) want = 0;
        m_phase = (m_state == 0) ? 0 : (m_phase + 1) % TD;
        m_state = n_state;
        m_tgt = n_tgt;
        m_en = want;
        m_mode = want && dn;
        m_clr = (n_state == 0);
        m_spd = spd_n;
    endtask

    task automatic check_all();
        chk("state", 8'(bus.state), 8'(m_state));
        chk("target", 8'(bus.target), 8'(m_tgt));
        chk("engaged", 8'(bus.engaged), 8'(m_state == 2));
        chk("cnt_enable", 8'(bus.cnt_enable), 8'(m_en));
        chk("cnt_mode", 8'(bus.cnt_mode), 8'(m_mode));
        chk("cnt_clear", 8'(bus.cnt_clear), 8'(m_clr));
        chk("speed", 8'(bus.speed_cnt), 8'(m_spd));
        chk("back_to_back_en", 8'(prev_en && bus.cnt_enable), 8'd0);
        prev_en = bus.cnt_enable;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            model_clk();
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic drive(input bit p, input bit s, input bit r, input bit c,
                         input bit b, input bit a, input bit d);
        bus.power = p; bus.set = s; bus.resume = r; bus.cancel = c;
        bus.brake = b; bus.accel = a; bus.decel = d;
    endtask

    initial begin
        int n;
        int pulses;
        model_reset();
        m_spd = 0;
        prev_en = 0;
        drive(0, 0, 0, 0, 0, 0, 0);

        // Reset and power-up
        cyc(3);
        chk("reset_clear", 8'(bus.cnt_clear), 8'd1);
        chk("reset_state", 8'(bus.state), 8'd0);
        clear_n = 1'b1;
        cyc(10);
        chk("off_clear", 8'(bus.cnt_clear), 8'd1);
        bus.power = 1;
        cyc(1);
        chk("idle_state", 8'(bus.state), 8'd1);
        chk("idle_clear", 8'(bus.cnt_clear), 8'd0);

        // Manual accel to saturation
        bus.accel = 1;
        n = 0;
        while (!bus.cnt_enable && n < 10) begin
            cyc(1);
            n++;
        end
        chk("first_en_latency", 8'(n), 8'd4);
        pulses = 1;
        repeat (40) begin
            cyc(1);
            if (bus.cnt_enable) pulses++;
        end
        chk("accel_pulses", 8'(pulses), 8'd7);
        chk("accel_sat_speed", 8'(bus.speed_cnt), 8'd7);
        drive(1, 0, 0, 0, 1, 0, 1);
        cyc(40);
        chk("brake_floor_speed", 8'(bus.speed_cnt), 8'd0);
        drive(1, 0, 0, 0, 0, 0, 0);
        cyc(2);

        // Engage at speed 3, raise target by one
        bus.accel = 1;
        n = 0;
        while (m_spd != 3 && n < 30) begin
            cyc(1);
            n++;
        end
        bus.accel = 0;
        chk("speed_3", 8'(bus.speed_cnt), 8'd3);
        bus.set = 1;
        cyc(1);
        bus.set = 0;
        chk("set_target", 8'(bus.target), 8'd3);
        chk("set_state", 8'(bus.state), 8'd2);
        chk("set_engaged", 8'(bus.engaged), 8'd1);
        bus.accel = 1;
        cyc(TD);
        bus.accel = 0;
        cyc(12);
        chk("adj_target", 8'(bus.target), 8'd4);
        chk("adj_speed", 8'(bus.speed_cnt), 8'd4);

        // Brake for three ticks, then resume
        n = 0;
        while (m_phase != 0 && n < TD) begin
            cyc(1);
            n++;
        end
        bus.brake = 1;
        cyc(12);
        bus.brake = 0;
        cyc(3);
        chk("brake_state", 8'(bus.state), 8'd3);
        chk("brake_engaged", 8'(bus.engaged), 8'd0);
        chk("brake_speed", 8'(bus.speed_cnt), 8'd1);
        chk("brake_target", 8'(bus.target), 8'd4);
        bus.resume = 1;
        cyc(1);
        bus.resume = 0;
        cyc(16);
        chk("resume_state", 8'(bus.state), 8'd2);
        chk("resume_speed", 8'(bus.speed_cnt), 8'd4);

        // Brake outranks set; then power-off mid-cruise
        bus.accel = 1;
        cyc(TD);
        drive(1, 1, 0, 0, 1, 0, 0);
        cyc(1);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("prio_state", 8'(bus.state), 8'd3);
        chk("prio_target", 8'(bus.target), 8'd5);
        bus.resume = 1;
        cyc(1);
        bus.resume = 0;
        cyc(8);
        bus.power = 0;
        cyc(1);
        chk("poff_state", 8'(bus.state), 8'd0);
        chk("poff_target", 8'(bus.target), 8'd0);
        chk("poff_clear", 8'(bus.cnt_clear), 8'd1);
        cyc(10);

        // Async reset in the middle of an enable pulse
        drive(1, 0, 0, 0, 0, 1, 0);
        n = 0;
        while (bus.cnt_enable !== 1'b1 && n < 20) begin
            cyc(1);
            n++;
        end
        chk("pulse_seen", 8'(bus.cnt_enable), 8'd1);
        #1 clear_n = 1'b0;
        model_reset();
        #1;
        chk("async_enable", 8'(bus.cnt_enable), 8'd0);
        chk("async_clear", 8'(bus.cnt_clear), 8'd1);
        chk("async_state", 8'(bus.state), 8'd0);
        bus.accel = 0;
        cyc(3);
        clear_n = 1'b1;
        cyc(1);
        chk("rst_release_state", 8'(bus.state), 8'd1);
        cyc(6);

        // Randomized traffic against the model
        repeat (400) begin
            drive($urandom_range(31) != 0, $urandom_range(15) == 0, $urandom_range(15) == 0,
                  $urandom_range(31) == 0, $urandom_range(7) == 0, $urandom_range(2) == 0,
                  $urandom_range(3) == 0);
            cyc(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
